// File: rtl/adder8_structure_if.sv
// Operand/result bundle for the registered 8-bit ripple-carry adder.
// The master drives operands and carry-in; the slave (adder) returns sum and carry-out.
interface adder8_structure_if;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       out;

    modport master (output a, b, cin, input  sum, out);
    modport slave  (input  a, b, cin, output sum, out);
endinterface

// File: rtl/adder8_structure.sv
// Registered 8-bit ripple-carry adder built from gate-level full-adder cells.
// Result {out, sum} = a + b + cin, one clock of latency.

// One-bit full adder from xor/and/or primitives.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    wire xy_x;
    wire xy_a;
    wire xc_a;
    wire yc_a;

    xor g_x1 (xy_x, x, y);
    xor g_x2 (s, xy_x, ci);
    and g_a1 (xy_a, x, y);
    and g_a2 (xc_a, x, ci);
    and g_a3 (yc_a, y, ci);
    or  g_o1 (co, xy_a, xc_a, yc_a);
endmodule

module adder8_structure (
    input  logic                clk,
    input  logic                rst_n,
    adder8_structure_if.slave   bus
);
    localparam int unsigned W = 8;

    wire [W:0]   carry;
    wire [W-1:0] s;

    assign carry[0] = bus.cin;

    // Ripple chain: carry out of bit i feeds bit i+1.
    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .x  (bus.a[i]),
            .y  (bus.b[i]),
            .ci (carry[i]),
            .s  (s[i]),
            .co (carry[i+1])
        );
    end

    // Output registers; reset clears the result without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sum <= '0;
            bus.out <= 1'b0;
        end else begin
            bus.sum <= s;
            bus.out <= carry[W];
        end
    end
endmodule

// File: tb/tb_adder8_structure.sv
// Self-checking bench for adder8_structure: arithmetic reference model,
// per-cycle compare, literal boundary checks, exhaustive sweep plus random vectors.
module tb_adder8_structure;
    logic clk;
    logic rst_n;
    adder8_structure_if bus ();

    adder8_structure dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    logic        check_en   = 1'b0;
    logic [8:0]  model_q    = 9'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 9-bit unsigned sum of the operands present at the last capturing edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_q <= 9'd0;
        else        model_q <= 9'(bus.a) + 9'(bus.b) + 9'(bus.cin);
    end

    // Every-cycle compare against the model, away from the capturing edge.
    always @(negedge clk) begin
        if (check_en) begin
            vectors++;
            if ({bus.out, bus.sum} !== model_q) begin
                miscompares++;
                $display("FAIL model_cmp: got %h expected %h (a=%h b=%h cin=%b)",
                         {bus.out, bus.sum}, model_q, bus.a, bus.b, bus.cin);
            end
        end
    end

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one operand set, let one edge capture it, then check the literal result.
    task automatic apply(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [8:0] exp);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = cin;
        @(posedge clk);
        #1;
        check(name, {bus.out, bus.sum}, exp);
    endtask

    initial begin
        rst_n = 1'b1;
        bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b1;
        #1 rst_n = 1'b0;
        check_en = 1'b1;

        // Clock edges ignored while in reset.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("reset_hold", {bus.out, bus.sum}, 9'h000);
        end

        @(negedge clk);
        rst_n = 1'b1;

        apply("basic_add",     8'h07, 8'h07, 1'b1, 9'h00F);
        apply("carry_prop_b1", 8'hFF, 8'h01, 1'b0, 9'h100);
        apply("carry_prop_ci", 8'hFF, 8'h00, 1'b1, 9'h100);
        apply("max_operands",  8'hFF, 8'hFF, 1'b1, 9'h1FF);
        apply("all_zero",      8'h00, 8'h00, 1'b0, 9'h000);
        apply("load_55",       8'h50, 8'h05, 1'b0, 9'h055);

        // Asynchronous reset between edges, then release and capture.
        #2 rst_n = 1'b0;
        #1 check("async_reset", {bus.out, bus.sum}, 9'h000);
        bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b1;
        @(negedge clk);
        check("reset_still_low", {bus.out, bus.sum}, 9'h000);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("release_load", {bus.out, bus.sum}, 9'h031);

        // Exhaustive operand sweep with carry-in toggling each cycle.
        for (int ia = 0; ia < 256; ia++) begin
            for (int ib = 0; ib < 256; ib++) begin
                @(negedge clk);
                bus.a   = 8'(ia);
                bus.b   = 8'(ib);
                bus.cin = ~bus.cin;
            end
        end

        // Random vectors with an occasional mid-cycle reset pulse.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.a   = 8'($urandom_range(255));
            bus.b   = 8'($urandom_range(255));
            bus.cin = 1'($urandom_range(1));
            if ($urandom_range(49) == 0) begin
                #2 rst_n = 1'b0;
                #1 check("rand_async_reset", {bus.out, bus.sum}, 9'h000);
                #1 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
